// File: rtl/shot_pool_manager_pkg.sv
// Shared types for the shot pool: slot record, slot state and screen geometry.
package shot_pkg;

  localparam int COORD_W  = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } shot_t;

  typedef enum logic {IDLE = 1'b0, FLY = 1'b1} slot_state_e;

  function automatic slot_state_e slot_state(input shot_t s);
    return s.active ? FLY : IDLE;
  endfunction

endpackage

// File: rtl/shot_pool_manager_btn_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// The pulse appears three clocks after the raw input rises.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q && !prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/shot_pool_manager.sv
// Pool of NUM_SHOTS projectiles launched from the motion centroid, moved once per frame,
// plus a registered pixel overlay flag. Optional launch cooldown: define SHOT_COOLDOWN_EN.
module shot_pool_manager
  import shot_pkg::*;
#(
  parameter int NUM_SHOTS       = 8,
  parameter int SPEED           = 4,
  parameter int SHOT_W          = 4,
  parameter int SHOT_H          = 8,
  parameter int FRAME_END_LINE  = 480,
  parameter int COOLDOWN_FRAMES = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    DE,
  input  logic [9:0]              x_pixel,
  input  logic [9:0]              y_pixel,
  input  logic                    shot_btn,
  input  logic                    motion_valid,
  input  logic [9:0]              com_x,
  input  logic [9:0]              com_y,
  output logic [NUM_SHOTS-1:0]    shot_active,
  output logic [10*NUM_SHOTS-1:0] shot_x_flat,
  output logic [10*NUM_SHOTS-1:0] shot_y_flat,
  output logic                    overlay_hit,
  output logic                    frame_tick,
  output logic                    launch_drop,
  output logic [4:0]              active_count
);

  localparam logic [9:0]  SPEED_C   = 10'(SPEED);
  localparam logic [9:0]  SHOT_H_C  = 10'(SHOT_H);
  localparam logic [9:0]  FEL_C     = 10'(FRAME_END_LINE);
  localparam logic [10:0] SHOT_W_M1 = 11'(SHOT_W - 1);
  localparam logic [10:0] SHOT_H_M1 = 11'(SHOT_H - 1);

  // Launch point sits one box height above the centroid, saturating at the top row.
  function automatic logic [9:0] clamp_launch_y(input logic [9:0] cy);
    return (cy < SHOT_H_C) ? 10'd0 : cy - SHOT_H_C;
  endfunction

  shot_t       slot_q [NUM_SHOTS];
  shot_t       slot_d [NUM_SHOTS];
  logic        frame_cond_q, frame_cond_d;
  logic        frame_tick_q, frame_tick_d;
  logic        launch_drop_q, launch_drop_d;
  logic        overlay_hit_q, overlay_hit_d;
  logic [4:0]  active_count_q, active_count_d;
  logic        press_pulse;
  logic        cooldown_busy;
  logic        can_launch, launch_ok, free_found, hit_any;
  logic [10:0] px, py, sx, sy;

  btn_sync_edge u_btn (
    .clk    (clk),
    .rst_n  (reset),
    .btn_in (shot_btn),
    .pulse  (press_pulse)
  );

  always_comb begin
    frame_cond_d = (y_pixel == FEL_C) && (x_pixel == 10'd0);
    frame_tick_d = frame_cond_d && !frame_cond_q;
  end

  // Movement first, then launch into the lowest slot that is idle *now*; a slot
  // retiring on this tick is still FLY in slot_q so it can never be the target.
  always_comb begin
    slot_d     = slot_q;
    free_found = 1'b0;
    can_launch = press_pulse && motion_valid && !cooldown_busy;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (frame_tick_q && slot_state(slot_q[i]) == FLY) begin
        if (slot_q[i].y >= SPEED_C) slot_d[i].y = slot_q[i].y - SPEED_C;
        else                        slot_d[i].active = 1'b0;
      end
    end
    for (int i = 0; i < NUM_SHOTS; i++) begin
      if (slot_state(slot_q[i]) == IDLE && !free_found) begin
        free_found = 1'b1;
        if (can_launch) slot_d[i] = '{active: 1'b1, x: com_x, y: clamp_launch_y(com_y)};
      end
    end
    launch_ok      = can_launch && free_found;
    launch_drop_d  = press_pulse && !launch_ok;
    active_count_d = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      active_count_d = active_count_d + 5'(slot_d[i].active);
    end
  end

`ifdef SHOT_COOLDOWN_EN
  localparam logic [15:0] COOLDOWN_C = 16'(COOLDOWN_FRAMES);
  logic [15:0] cool_q, cool_d;

  assign cooldown_busy = (cool_q != 16'd0);

  always_comb begin
    cool_d = cool_q;
    if (launch_ok)                           cool_d = COOLDOWN_C;
    else if (frame_tick_q && cooldown_busy)  cool_d = cool_q - 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cool_q <= '0;
    else        cool_q <= cool_d;
  end
`else
  assign cooldown_busy = 1'b0;
`endif

  // 11-bit bounds keep boxes near the right edge from wrapping.
  always_comb begin
    hit_any = 1'b0;
    px      = {1'b0, x_pixel};
    py      = {1'b0, y_pixel};
    sx      = '0;
    sy      = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      sx = {1'b0, slot_q[i].x};
      sy = {1'b0, slot_q[i].y};
      if (slot_state(slot_q[i]) == FLY && px >= sx && px <= sx + SHOT_W_M1 &&
          py >= sy && py <= sy + SHOT_H_M1)
        hit_any = 1'b1;
    end
    overlay_hit_d = DE && hit_any;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SHOTS; i++) slot_q[i] <= '0;
      frame_cond_q   <= 1'b0;
      frame_tick_q   <= 1'b0;
      launch_drop_q  <= 1'b0;
      overlay_hit_q  <= 1'b0;
      active_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) slot_q[i] <= slot_d[i];
      frame_cond_q   <= frame_cond_d;
      frame_tick_q   <= frame_tick_d;
      launch_drop_q  <= launch_drop_d;
      overlay_hit_q  <= overlay_hit_d;
      active_count_q <= active_count_d;
    end
  end

  always_comb begin
    shot_active = '0;
    shot_x_flat = '0;
    shot_y_flat = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      shot_active[i]          = slot_q[i].active;
      shot_x_flat[10*i +: 10] = slot_q[i].x;
      shot_y_flat[10*i +: 10] = slot_q[i].y;
    end
  end

  assign overlay_hit  = overlay_hit_q;
  assign frame_tick   = frame_tick_q;
  assign launch_drop  = launch_drop_q;
  assign active_count = active_count_q;

endmodule

// File: doc/shot_pool_manager.md
Name: shot_pool_manager

Overview:
Parametrised successor to the fixed five-shot logic that sits beside motion_coordinate in Core. Holds NUM_SHOTS projectile slots. A shot_btn press launches a shot from the current motion centre-of-mass (com_x/com_y). Each shot advances upward once per frame and retires off the top of the screen. The block also produces a registered per-pixel overlay flag that motion_display uses to paint shots.

Parameters:
NUM_SHOTS, 8, number of projectile slots (1..16)
SPEED, 4, pixels a shot moves up per frame tick
SHOT_W, 4, shot box width in pixels
SHOT_H, 8, shot box height in pixels
FRAME_END_LINE, 480, y_pixel value that marks end of the active frame
COOLDOWN_FRAMES, 10, minimum frame ticks between launches (only with SHOT_COOLDOWN_EN)

Ports:
clk  in  1  pixel clock, one pixel per cycle
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
DE  in  1  VGA active-video enable
x_pixel  in  10  current pixel column
y_pixel  in  10  current pixel row
shot_btn  in  1  raw asynchronous button input
motion_valid  in  1  com_x/com_y hold a valid centroid
com_x  in  10  launch x coordinate
com_y  in  10  launch y coordinate
shot_active  out  NUM_SHOTS  per-slot active flag
shot_x_flat  out  10*NUM_SHOTS  slot i x in bits [10i+9:10i]
shot_y_flat  out  10*NUM_SHOTS  slot i y in bits [10i+9:10i]
overlay_hit  out  1  registered flag: current pixel lies inside an active shot box
frame_tick  out  1  one-cycle pulse at end of frame
launch_drop  out  1  one-cycle pulse: press rejected
active_count  out  5  number of active slots

Behaviour:
- Reset: all slots inactive, x = y = 0. overlay_hit, frame_tick, launch_drop = 0. active_count = 0. Sync/edge registers and cooldown counter cleared. Reset mid-flight discards all shots immediately.
- Button path: 2-FF synchroniser, then rising-edge detect. This gives exactly one press pulse per press, 3 cycles after the input edge.
- Frame tick: a registered edge detect on (y_pixel == FRAME_END_LINE && x_pixel == 0). It produces exactly one cycle per frame.
- Per-slot state machine: IDLE -> FLY on launch. FLY -> IDLE on a frame tick when y < SPEED.
- Launch: on a press pulse with motion_valid = 1, the lowest-index IDLE slot loads:
  - x = com_x
  - y = com_y - SHOT_H, clamped to 0 when com_y < SHOT_H
  - The slot becomes active the next cycle.
- Launch drop: launch_drop pulses and no slot changes if motion_valid = 0, if every slot is FLY, or if cooldown is active.
- Frame tick movement: every FLY slot with y >= SPEED sets y <= y - SPEED. A FLY slot with y < SPEED goes IDLE, and its x/y are held.
- Simultaneous launch and frame tick: the launched slot loads its launch value and is not moved this tick. All other slots move normally. A slot retiring on this tick is not eligible as the launch target this cycle.
- Overlay:
  - overlay_hit is registered with 1-cycle latency relative to x_pixel/y_pixel/DE.
  - It is 1 iff DE = 1 and some FLY slot satisfies sx <= x_pixel <= sx+SHOT_W-1 and sy <= y_pixel <= sy+SHOT_H-1.
  - Comparisons use 11-bit sums, so there is no wrap at x = 636..639.
- active_count is a registered popcount of the slot active flags, updated the same cycle as slot state.

Optional Feature:
SHOT_COOLDOWN_EN.
- Defined: a launch loads a counter with COOLDOWN_FRAMES. The counter decrements on each frame tick. Presses while the counter is nonzero are dropped (launch_drop = 1).
- Undefined: no counter exists, and a launch is possible on every press.

Decomposition:
- Package shot_pkg contains:
  - COORD_W = 10, H_ACTIVE = 640, V_ACTIVE = 480
  - typedef struct packed shot_t {logic active; logic [9:0] x; logic [9:0] y;}
  - slot state enum {IDLE, FLY}
- One sub-module, btn_sync_edge: synchroniser plus rising-edge pulse, reused later for other buttons.

Test Plan:
1. Reset, motion_valid = 1, com = (100, 200), press once -> slot0 active at x = 100, y = 192; active_count = 1; launch_drop = 0.
2. Continuing from 1, run 3 frames -> slot0 y = 180. Pixel (101, 185) with DE = 1 -> overlay_hit = 1 one cycle later. Pixel (104, 185) -> 0.
3. Nine presses with motion_valid = 1 and no frame ticks in between -> slots 0..7 fill and active_count = 8. The 9th press gives a launch_drop pulse and no slot changes.
4. Shot at y = 3 plus a frame tick -> slot goes IDLE and active_count decrements. A press on the same cycle as the tick lands in a different idle slot, not the retiring one.
5. Press with motion_valid = 0 -> launch_drop = 1 and active_count unchanged. Assert reset mid-flight with 4 active -> all shot_active = 0 asynchronously.
6. With SHOT_COOLDOWN_EN: press, then press again after 5 frames -> dropped. Press after 10 frames -> accepted.
